// File: rtl/core_pkg.sv
// Shared types and instruction-field helpers for the two-stage pipe_core processor.
package core_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_XOR  = 3'b011,
    OP_LD   = 3'b100,
    OP_ST   = 3'b101,
    OP_BNZ  = 3'b110,
    OP_HALT = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } run_t;

  // Field offsets for the default 9-bit / 8-register configuration
  localparam int unsigned DEF_IW = 9;
  localparam int unsigned DEF_A  = 3;
  localparam int unsigned OP_LSB = DEF_IW - 3;
  localparam int unsigned RA_LSB = DEF_IW - 3 - DEF_A;
  localparam int unsigned RB_LSB = DEF_IW - 3 - 2 * DEF_A;

  function automatic int unsigned opLsb(input int unsigned iw);
    return iw - 3;
  endfunction

  function automatic int unsigned raLsb(input int unsigned iw, input int unsigned a);
    return iw - 3 - a;
  endfunction

  function automatic int unsigned rbLsb(input int unsigned iw, input int unsigned a);
    return iw - 3 - 2 * a;
  endfunction

endpackage

// File: rtl/core_regfile.sv
// 2**A x W register file: two combinational read ports, one write port, sync active-low clear.
module core_regfile #(
  parameter int unsigned W = 8,
  parameter int unsigned A = 3
) (
  input  logic         clk,
  input  logic         clearN,
  input  logic [A-1:0] rdAddrA,
  input  logic [A-1:0] rdAddrB,
  output logic [W-1:0] rdDataA,
  output logic [W-1:0] rdDataB,
  input  logic         wrEn,
  input  logic [A-1:0] wrAddr,
  input  logic [W-1:0] wrData
);

  localparam int unsigned DEPTH = 2 ** A;

  logic [W-1:0] regs [DEPTH];

  always_ff @(posedge clk) begin
    if (!clearN) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn) begin
      regs[wrAddr] <= wrData;
    end
  end

  assign rdDataA = regs[rdAddrA];
  assign rdDataB = regs[rdAddrB];

endmodule

// File: rtl/pipe_core.sv
// Two-stage (fetch/execute) 9-bit processor core with Start/Ack run control.
// Define CORE_CYCLE_COUNT_EN to build the saturating execute-cycle counter on CycleCt.
module pipe_core
  import core_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned A   = 3,
  parameter int unsigned PCW = 10,
  parameter int unsigned IW  = 9
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [PCW-1:0] StartAddr,
  output logic [PCW-1:0] InstAddr,
  input  logic [IW-1:0]  InstData,
  output logic [W-1:0]   MemAddr,
  output logic [W-1:0]   MemWrData,
  output logic           MemWrEn,
  input  logic [W-1:0]   MemRdData,
  output logic           Ack,
  output logic [15:0]    CycleCt
);

  localparam int unsigned OPL = opLsb(IW);
  localparam int unsigned RAL = raLsb(IW, A);
  localparam int unsigned RBL = rbLsb(IW, A);
  localparam int unsigned TW  = (W < PCW) ? W : PCW;
  localparam logic [PCW-1:0] PC_ONE = {{(PCW-1){1'b0}}, 1'b1};

  run_t           state;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  ir;
  logic           irv;
  logic           ack;

  op_t            op;
  logic [A-1:0]   ra;
  logic [A-1:0]   rb;
  logic [W-1:0]   rdA;
  logic [W-1:0]   rdB;
  logic [W-1:0]   aluY;
  logic           wrOp;
  logic           wrEn;
  logic           exec;
  logic           brTaken;
  logic           halt;
  logic           startOk;
  logic [PCW-1:0] brTarget;

  assign op = op_t'(ir[OPL +: 3]);
  assign ra = ir[RAL +: A];
  assign rb = ir[RBL +: A];

  assign exec    = irv && (state == RUN);
  assign startOk = Start && ((state == IDLE) || (state == DONE));

  core_regfile #(
    .W(W),
    .A(A)
  ) uRegs (
    .clk    (Clk),
    .clearN (Reset),
    .rdAddrA(ra),
    .rdAddrB(rb),
    .rdDataA(rdA),
    .rdDataB(rdB),
    .wrEn   (wrEn),
    .wrAddr (ra),
    .wrData (aluY)
  );

  always_comb begin
    aluY = '0;
    wrOp = 1'b0;
    case (op)
      OP_ADD: begin aluY = rdA + rdB;  wrOp = 1'b1; end
      OP_SUB: begin aluY = rdA - rdB;  wrOp = 1'b1; end
      OP_AND: begin aluY = rdA & rdB;  wrOp = 1'b1; end
      OP_XOR: begin aluY = rdA ^ rdB;  wrOp = 1'b1; end
      OP_LD:  begin aluY = MemRdData;  wrOp = 1'b1; end
      default: ;
    endcase
  end

  // Branch target is R[rb] zero-extended or truncated to the PC width
  always_comb begin
    brTarget = '0;
    brTarget[TW-1:0] = rdB[TW-1:0];
  end

  assign wrEn    = exec && wrOp;
  assign brTaken = exec && (op == OP_BNZ) && (rdA != '0);
  assign halt    = exec && (op == OP_HALT);

  assign InstAddr  = pc;
  assign MemAddr   = rdB;
  assign MemWrData = rdA;
  assign MemWrEn   = exec && (op == OP_ST);
  assign Ack       = ack;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= '0;
      ir    <= '0;
      irv   <= 1'b0;
      ack   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (startOk) begin
            state <= RUN;
            pc    <= StartAddr;
            irv   <= 1'b0;
            ack   <= 1'b0;
          end
        end
        RUN: begin
          if (halt) begin
            state <= DONE;
            ack   <= 1'b1;
            irv   <= 1'b0;
          end else if (brTaken) begin
            pc  <= brTarget;
            irv <= 1'b0;
          end else begin
            ir  <= InstData;
            irv <= 1'b1;
            pc  <= pc + PC_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CORE_CYCLE_COUNT_EN
  logic [15:0] cycleCt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cycleCt <= '0;
    end else if (startOk) begin
      cycleCt <= '0;
    end else if ((state == RUN) && (cycleCt != '1)) begin
      cycleCt <= cycleCt + 16'd1;
    end
  end

  assign CycleCt = cycleCt;
`else
  assign CycleCt = '0;
`endif

endmodule

// File: tb/tb_pipe_core.sv
// Scoreboarded bench for pipe_core: models instruction/data memories and checks stores, latency and run control.
module tb_pipe_core;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartAddr;
  logic [9:0]  InstAddr;
  logic [8:0]  InstData;
  logic [7:0]  MemAddr;
  logic [7:0]  MemWrData;
  logic        MemWrEn;
  logic [7:0]  MemRdData;
  logic        Ack;
  logic [15:0] CycleCt;

  logic [8:0]  imem [1024];
  logic [7:0]  dmem [256];
  logic [7:0]  dmemInit [256];
  logic        loadReq;
  logic        ignoreStores;
  logic [15:0] expQ [$];
  int          nVec;
  int          nFail;

`ifdef CORE_CYCLE_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  localparam logic [2:0] iADD = 3'b000, iSUB = 3'b001, iAND = 3'b010, iXOR = 3'b011;
  localparam logic [2:0] iLD = 3'b100, iST = 3'b101, iBNZ = 3'b110, iHALT = 3'b111;

  pipe_core dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .StartAddr(StartAddr),
    .InstAddr (InstAddr),
    .InstData (InstData),
    .MemAddr  (MemAddr),
    .MemWrData(MemWrData),
    .MemWrEn  (MemWrEn),
    .MemRdData(MemRdData),
    .Ack      (Ack),
    .CycleCt  (CycleCt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign InstData  = imem[InstAddr];
  assign MemRdData = dmem[MemAddr];

  always @(posedge Clk) begin
    if (loadReq) dmem <= dmemInit;
    else if (MemWrEn === 1'b1) dmem[MemAddr] <= MemWrData;
  end

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb);
    return {op, ra, rb};
  endfunction

  function automatic int expCt(input int lat);
    return (CNT_EN != 0) ? lat : 0;
  endfunction

  task automatic clearMems();
    for (int i = 0; i < 1024; i++) imem[i] = enc(iHALT, 3'd0, 3'd0);
    for (int i = 0; i < 256; i++) dmemInit[i] = 8'h00;
  endtask

  task automatic doReset();
    @(negedge Clk);
    Start   = 1'b0;
    Reset   = 1'b0;
    loadReq = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset   = 1'b1;
    loadReq = 1'b0;
  endtask

  task automatic startProg(input logic [9:0] addr);
    @(negedge Clk);
    StartAddr = addr;
    Start     = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic waitAck(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge Clk);
      #1;
      if (Ack === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    clearMems();
    StartAddr = 10'h155;
    Start     = 1'b1;
    Reset     = 1'b0;
    loadReq   = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    nVec++; if (Ack !== 1'b0) begin nFail++; $display("FAIL reset_ack got=%b exp=0", Ack); end
    nVec++; if (InstAddr !== 10'h000) begin nFail++; $display("FAIL reset_instaddr got=%h exp=000", InstAddr); end
    nVec++; if (MemWrEn !== 1'b0) begin nFail++; $display("FAIL reset_memwren got=%b exp=0", MemWrEn); end
    nVec++; if (CycleCt !== 16'h0000) begin nFail++; $display("FAIL reset_cyclect got=%h exp=0000", CycleCt); end
    @(negedge Clk);
    Reset   = 1'b1;
    Start   = 1'b0;
    loadReq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk);
      #1;
      nVec++;
      if ({Ack, MemWrEn, InstAddr, CycleCt} !== 28'h0) begin
        nFail++;
        $display("FAIL idle_stable cyc=%0d got ack=%b we=%b pc=%h ct=%h exp all 0", i, Ack, MemWrEn, InstAddr, CycleCt);
      end
    end
  endtask

  task automatic test_load_add_store();
    int lat;
    clearMems();
    dmemInit[0] = 8'd5; dmemInit[1] = 8'd7; dmemInit[5] = 8'd1;
    imem[10'h010] = enc(iLD, 3'd1, 3'd0);
    imem[10'h011] = enc(iLD, 3'd3, 3'd1);
    imem[10'h012] = enc(iLD, 3'd2, 3'd3);
    imem[10'h013] = enc(iADD, 3'd1, 3'd2);
    imem[10'h014] = enc(iST, 3'd1, 3'd2);
    imem[10'h015] = enc(iHALT, 3'd0, 3'd0);
    doReset();
    expQ.push_back({8'h07, 8'h0C});
    startProg(10'h010);
    waitAck(100, lat);
    nVec++; if (lat !== 7) begin nFail++; $display("FAIL las_latency got=%0d exp=7", lat); end
    nVec++; if (CycleCt !== 16'(expCt(7))) begin nFail++; $display("FAIL las_cyclect got=%0d exp=%0d", CycleCt, expCt(7)); end
    repeat (2) begin
      @(posedge Clk);
      #1;
      nVec++;
      if ({Ack, InstAddr} !== {1'b1, 10'h016}) begin
        nFail++;
        $display("FAIL las_frozen got ack=%b pc=%h exp ack=1 pc=016", Ack, InstAddr);
      end
    end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL las_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_alu();
    int lat;
    clearMems();
    dmemInit[0] = 8'd5; dmemInit[1] = 8'd7; dmemInit[5] = 8'd1;
    imem[10'h200] = enc(iLD, 3'd1, 3'd0);
    imem[10'h201] = enc(iLD, 3'd3, 3'd1);
    imem[10'h202] = enc(iLD, 3'd2, 3'd3);
    imem[10'h203] = enc(iXOR, 3'd4, 3'd1);
    imem[10'h204] = enc(iSUB, 3'd4, 3'd2);
    imem[10'h205] = enc(iST, 3'd4, 3'd3);
    imem[10'h206] = enc(iAND, 3'd4, 3'd1);
    imem[10'h207] = enc(iST, 3'd4, 3'd3);
    imem[10'h208] = enc(iSUB, 3'd5, 3'd2);
    imem[10'h209] = enc(iXOR, 3'd5, 3'd1);
    imem[10'h20A] = enc(iST, 3'd5, 3'd4);
    imem[10'h20B] = enc(iADD, 3'd5, 3'd5);
    imem[10'h20C] = enc(iST, 3'd5, 3'd3);
    doReset();
    expQ.push_back({8'h01, 8'hFE});
    expQ.push_back({8'h01, 8'h04});
    expQ.push_back({8'h04, 8'hFC});
    expQ.push_back({8'h01, 8'hF8});
    startProg(10'h200);
    waitAck(100, lat);
    nVec++; if (lat !== 15) begin nFail++; $display("FAIL alu_latency got=%0d exp=15", lat); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL alu_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_branch_flush();
    int lat;
    clearMems();
    dmemInit[0] = 8'd3; dmemInit[3] = 8'h20;
    imem[10'h010] = enc(iLD, 3'd1, 3'd0);
    imem[10'h011] = enc(iLD, 3'd2, 3'd1);
    imem[10'h012] = enc(iBNZ, 3'd1, 3'd2);
    imem[10'h013] = enc(iADD, 3'd2, 3'd2);
    imem[10'h014] = enc(iST, 3'd1, 3'd0);
    imem[10'h020] = enc(iST, 3'd2, 3'd1);
    doReset();
    expQ.push_back({8'h03, 8'h20});
    startProg(10'h010);
    waitAck(100, lat);
    nVec++; if (lat !== 7) begin nFail++; $display("FAIL bnz_taken_latency got=%0d exp=7", lat); end
    nVec++; if (InstAddr !== 10'h022) begin nFail++; $display("FAIL bnz_taken_pc got=%h exp=022", InstAddr); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL bnz_taken_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_branch_not_taken();
    int lat;
    clearMems();
    dmemInit[0] = 8'd9;
    imem[10'h030] = enc(iLD, 3'd1, 3'd0);
    imem[10'h031] = enc(iBNZ, 3'd0, 3'd1);
    imem[10'h032] = enc(iADD, 3'd1, 3'd1);
    imem[10'h033] = enc(iST, 3'd1, 3'd0);
    doReset();
    expQ.push_back({8'h00, 8'h12});
    startProg(10'h030);
    waitAck(100, lat);
    nVec++; if (lat !== 6) begin nFail++; $display("FAIL bnz_nt_latency got=%0d exp=6", lat); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL bnz_nt_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_restart();
    int e;
    int lat;
    clearMems();
    dmemInit[0] = 8'd2;
    imem[10'h040] = enc(iLD, 3'd1, 3'd0);
    imem[10'h041] = enc(iADD, 3'd1, 3'd1);
    imem[10'h042] = enc(iADD, 3'd1, 3'd1);
    imem[10'h043] = enc(iST, 3'd1, 3'd0);
    imem[10'h050] = enc(iST, 3'd0, 3'd0);
    imem[10'h100] = enc(iLD, 3'd2, 3'd0);
    imem[10'h101] = enc(iST, 3'd2, 3'd2);
    doReset();
    expQ.push_back({8'h00, 8'h08});
    startProg(10'h040);
    @(negedge Clk);
    StartAddr = 10'h050;
    Start     = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    waitAck(100, e);
    lat = (e < 0) ? -1 : e + 1;
    nVec++; if (lat !== 6) begin nFail++; $display("FAIL ignore_start_latency got=%0d exp=6", lat); end
    repeat (2) @(posedge Clk);
    #1;
    nVec++; if (CycleCt !== 16'(expCt(6))) begin nFail++; $display("FAIL done_hold_cyclect got=%0d exp=%0d", CycleCt, expCt(6)); end
    nVec++; if (Ack !== 1'b1) begin nFail++; $display("FAIL done_hold_ack got=%b exp=1", Ack); end
    expQ.push_back({8'h08, 8'h08});
    startProg(10'h100);
    nVec++;
    if ({Ack, InstAddr, CycleCt} !== {1'b0, 10'h100, 16'h0000}) begin
      nFail++;
      $display("FAIL restart_edge got ack=%b pc=%h ct=%h exp ack=0 pc=100 ct=0000", Ack, InstAddr, CycleCt);
    end
    waitAck(100, lat);
    nVec++; if (lat !== 4) begin nFail++; $display("FAIL restart_latency got=%0d exp=4", lat); end
    nVec++; if (CycleCt !== 16'(expCt(4))) begin nFail++; $display("FAIL restart_cyclect got=%0d exp=%0d", CycleCt, expCt(4)); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL restart_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_wrap();
    int e;
    clearMems();
    dmemInit[0] = 8'd4;
    imem[10'h3FF] = enc(iLD, 3'd1, 3'd0);
    imem[10'h000] = enc(iST, 3'd1, 3'd1);
    doReset();
    expQ.push_back({8'h04, 8'h04});
    startProg(10'h3FF);
    nVec++; if (InstAddr !== 10'h3FF) begin nFail++; $display("FAIL wrap_start_pc got=%h exp=3ff", InstAddr); end
    @(posedge Clk);
    #1;
    nVec++; if (InstAddr !== 10'h000) begin nFail++; $display("FAIL wrap_pc got=%h exp=000", InstAddr); end
    waitAck(100, e);
    nVec++; if (e !== 3) begin nFail++; $display("FAIL wrap_latency got=%0d exp=3", e); end
    nVec++; if (InstAddr !== 10'h002) begin nFail++; $display("FAIL wrap_final_pc got=%h exp=002", InstAddr); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL wrap_pending got=%0d exp=0", expQ.size()); end
  endtask

  task automatic test_reset_midrun();
    int lat;
    clearMems();
    dmemInit[0] = 8'd6;
    imem[10'h060] = enc(iLD, 3'd1, 3'd0);
    for (int i = 10'h061; i < 10'h070; i++) imem[i] = enc(iADD, 3'd1, 3'd1);
    imem[10'h070] = enc(iST, 3'd1, 3'd0);
    doReset();
    startProg(10'h060);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    ignoreStores = 1'b1;
    Reset        = 1'b0;
    @(posedge Clk);
    #1;
    nVec++;
    if ({Ack, MemWrEn, InstAddr, CycleCt} !== 28'h0) begin
      nFail++;
      $display("FAIL midrun_reset got ack=%b we=%b pc=%h ct=%h exp all 0", Ack, MemWrEn, InstAddr, CycleCt);
    end
    @(negedge Clk);
    Reset        = 1'b1;
    ignoreStores = 1'b0;
    @(posedge Clk);
    #1;
    nVec++; if (InstAddr !== 10'h000) begin nFail++; $display("FAIL midrun_idle_pc got=%h exp=000", InstAddr); end
    expQ.push_back({8'h00, 8'h00});
    startProg(10'h070);
    waitAck(100, lat);
    nVec++; if (lat !== 3) begin nFail++; $display("FAIL midrun_rerun_latency got=%0d exp=3", lat); end
    nVec++; if (expQ.size() !== 0) begin nFail++; $display("FAIL midrun_pending got=%0d exp=0", expQ.size()); end
  endtask

  initial begin
    nVec         = 0;
    nFail        = 0;
    Reset        = 1'b0;
    Start        = 1'b0;
    StartAddr    = '0;
    loadReq      = 1'b0;
    ignoreStores = 1'b0;

    fork
      forever begin
        logic [15:0] exp;
        @(negedge Clk);
        if (MemWrEn === 1'b1 && !ignoreStores) begin
          nVec++;
          if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL unexpected_store got addr=%h data=%h exp no store", MemAddr, MemWrData);
          end else begin
            exp = expQ.pop_front();
            if ({MemAddr, MemWrData} !== exp) begin
              nFail++;
              $display("FAIL store got addr=%h data=%h exp addr=%h data=%h", MemAddr, MemWrData, exp[15:8], exp[7:0]);
            end
          end
        end
      end
    join_none

    test_reset();
    test_load_add_store();
    test_alu();
    test_branch_flush();
    test_branch_not_taken();
    test_restart();
    test_wrap();
    test_reset_midrun();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
